// File: rtl/sram_adapter_pkg.sv
// Shared defaults and request payload type for the SRAM read/write adapter.
package sram_adapter_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 40;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 6;
  localparam int unsigned DEFAULT_NUM_WMASKS = 2;
  localparam int unsigned DEFAULT_RSP_DEPTH  = 4;

  // One request as offered on the req_* port group at the default widths.
  typedef struct packed {
    logic                          we;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_NUM_WMASKS-1:0] wmask;
    logic [DEFAULT_DATA_WIDTH-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// Synchronous response queue with occupancy count; head is the oldest entry.
module sram_rsp_fifo
  import sram_adapter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned DEPTH = DEFAULT_RSP_DEPTH,
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CW-1:0]    count
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A push into a full queue is only legal if the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage and pointers; storage is cleared so the head reads zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_rw_adapter.sv
// Valid/ready front end for a single-port SRAM macro with registered pins,
// a two-stage read tracker and an ordered response queue.
module sram_rw_adapter
  import sram_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_WMASKS = DEFAULT_NUM_WMASKS,
  parameter int unsigned RSP_DEPTH  = DEFAULT_RSP_DEPTH
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int unsigned CW = $clog2(RSP_DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  logic          accept;
  logic          rd_issued;
  logic          rd_in_macro;
  logic [1:0]    inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [SW-1:0] occupancy;

  // Every in-flight read already owns a queue slot, so the queue can never overflow.
  assign inflight  = {1'b0, rd_issued} + {1'b0, rd_in_macro};
  assign occupancy = SW'(fifo_count) + SW'(inflight);
  assign req_ready = !rst0 && (occupancy < SW'(RSP_DEPTH));
  assign accept    = req_valid && req_ready;

  // Macro pins: chip select pulses per accept, other pins hold between accepts.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      csb0   <= 1'b1;
      web0   <= 1'b1;
      wmask0 <= '0;
      addr0  <= '0;
      din0   <= '0;
    end else begin
      csb0 <= !accept;
      if (accept) begin
        addr0 <= req_addr;
        web0  <= !req_we;
        if (req_we) begin
          wmask0 <= req_wmask;
          din0   <= req_wdata;
        end
      end
    end
  end

  // Read tracker: pins driven (issued), then macro access; capture follows.
  always_ff @(posedge clk0) begin
    if (rst0) begin
      rd_issued   <= 1'b0;
      rd_in_macro <= 1'b0;
    end else begin
      rd_issued   <= accept && !req_we;
      rd_in_macro <= rd_issued;
    end
  end

  // dout0 is pushed on the edge after the macro access, before it goes stale.
  sram_rsp_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk0),
    .rst       (rst0),
    .push      (rd_in_macro),
    .push_data (dout0),
    .pop       (rsp_ready),
    .head      (rsp_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign rsp_valid = !fifo_empty;

endmodule

// File: tb/tb_sram_rw_adapter.sv
// Directed bench for sram_rw_adapter with a behavioural single-port macro.
module tb_sram_rw_adapter;
  import sram_adapter_pkg::*;

  localparam int unsigned DW = 40;
  localparam int unsigned AW = 6;
  localparam int unsigned NM = 2;
  localparam int unsigned LW = DW / NM;

  logic          clk0 = 1'b0;
  logic          rst0;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [NM-1:0] req_wmask;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          csb0;
  logic          web0;
  logic [NM-1:0] wmask0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] din0;
  logic [DW-1:0] dout0;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mem     [64];
  logic [DW-1:0] exp_mem [64];
  int            act_cnt = 0;
  logic          m_rd = 1'b0;
  logic          m_wr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [NM-1:0] m_mask = '0;
  logic [DW-1:0] m_din = '0;

  always #5 clk0 = ~clk0;

  sram_rw_adapter dut (
    .clk0      (clk0),
    .rst0      (rst0),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wmask (req_wmask),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .csb0      (csb0),
    .web0      (web0),
    .wmask0    (wmask0),
    .addr0     (addr0),
    .din0      (din0),
    .dout0     (dout0)
  );

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [NM-1:0] m);
    logic [DW-1:0] r;
    r = old;
    for (int l = 0; l < int'(NM); l++) begin
      if (m[l]) r[l*LW +: LW] = d[l*LW +: LW];
    end
    return r;
  endfunction

  // Macro: samples pins at posedge, writes at negedge, read data valid until just after the next posedge.
  always @(posedge clk0) begin
    m_wr   = !csb0 && !web0;
    m_rd   = !csb0 && web0;
    m_addr = addr0;
    m_mask = wmask0;
    m_din  = din0;
    if (!csb0) act_cnt++;
    #1 dout0 = 'x;
  end

  always @(negedge clk0) begin
    if (m_wr) mem[m_addr] = merge(mem[m_addr], m_din, m_mask);
    if (m_rd) dout0 = mem[m_addr];
  end

  // The adapter must never push into a full response queue.
  always @(posedge clk0) begin
    if (rst0 === 1'b0) begin
      assert (!(dut.u_rsp_fifo.push && dut.u_rsp_fifo.full)) else begin
        bad++;
        $display("FAIL fifo_push_when_full got=1 exp=0 at %0t", $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk0);
    #1;
  endtask

  function automatic sram_req_t mk(input logic we, input logic [AW-1:0] a, input logic [NM-1:0] m,
                                   input logic [DW-1:0] d);
    sram_req_t r;
    r.we = we; r.addr = a; r.wmask = m; r.wdata = d;
    return r;
  endfunction

  task automatic drive(input sram_req_t r);
    req_valid = 1'b1;
    req_we    = r.we;
    req_addr  = r.addr;
    req_wmask = r.wmask;
    req_wdata = r.wdata;
    if (r.we) exp_mem[r.addr] = merge(exp_mem[r.addr], r.wdata, r.wmask);
  endtask

  task automatic wait_rsp(input int max, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      if (rsp_valid) seen = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wmask = '0; req_wdata = '0; rsp_ready = 1'b0;
    tick(); tick();
    for (int i = 0; i < 64; i++) begin
      mem[i]     = 40'h10_0000_1000 + 40'(i);
      exp_mem[i] = mem[i];
    end
    total++; if (csb0 !== 1'b1) begin bad++; $display("FAIL reset_csb0 got=%b exp=1", csb0); end
    total++; if (web0 !== 1'b1) begin bad++; $display("FAIL reset_web0 got=%b exp=1", web0); end
    total++; if (wmask0 !== 2'b00) begin bad++; $display("FAIL reset_wmask0 got=%b exp=00", wmask0); end
    total++; if (addr0 !== 6'd0) begin bad++; $display("FAIL reset_addr0 got=%0d exp=0", addr0); end
    total++; if (din0 !== 40'h0) begin bad++; $display("FAIL reset_din0 got=%h exp=0", din0); end
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    total++; if (rsp_rdata !== 40'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
    rst0 = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", req_ready); end
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    drive(mk(1'b1, 6'd5, 2'b11, 40'hAB_CDEF_0123));
    tick();
    total++; if (csb0 !== 1'b0) begin bad++; $display("FAIL wr_csb0 got=%b exp=0", csb0); end
    total++; if (web0 !== 1'b0) begin bad++; $display("FAIL wr_web0 got=%b exp=0", web0); end
    total++; if (wmask0 !== 2'b11) begin bad++; $display("FAIL wr_wmask0 got=%b exp=11", wmask0); end
    total++; if (addr0 !== 6'd5) begin bad++; $display("FAIL wr_addr0 got=%0d exp=5", addr0); end
    total++; if (din0 !== 40'hAB_CDEF_0123) begin bad++; $display("FAIL wr_din0 got=%h exp=abcdef0123", din0); end
    drive(mk(1'b0, 6'd5, 2'b00, 40'h0));
    tick();
    total++; if (csb0 !== 1'b0) begin bad++; $display("FAIL rd_csb0 got=%b exp=0", csb0); end
    total++; if (web0 !== 1'b1) begin bad++; $display("FAIL rd_web0 got=%b exp=1", web0); end
    total++; if (wmask0 !== 2'b11) begin bad++; $display("FAIL rd_wmask0_hold got=%b exp=11", wmask0); end
    total++; if (din0 !== 40'hAB_CDEF_0123) begin bad++; $display("FAIL rd_din0_hold got=%h exp=abcdef0123", din0); end
    req_valid = 1'b0;
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid got=%b exp=0", rsp_valid); end
    total++; if (csb0 !== 1'b1) begin bad++; $display("FAIL rd_idle_csb0 got=%b exp=1", csb0); end
    tick();
    total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL rd_latency_valid got=%b exp=1", rsp_valid); end
    total++; if (rsp_rdata !== 40'hAB_CDEF_0123) begin bad++; $display("FAIL rd_data got=%h exp=abcdef0123", rsp_rdata); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rd_popped got=%b exp=0", rsp_valid); end
  endtask

  task automatic test_mask();
    bit seen;
    rsp_ready = 1'b1;
    drive(mk(1'b1, 6'd9, 2'b11, 40'hFF_FFFF_FFFF));
    tick();
    drive(mk(1'b1, 6'd9, 2'b01, 40'h00_0000_0000));
    tick();
    drive(mk(1'b0, 6'd9, 2'b00, 40'h0));
    tick();
    req_valid = 1'b0;
    wait_rsp(6, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL mask_timeout got=none exp=response"); end
    else if (rsp_rdata !== 40'hFF_FFF0_0000) begin
      bad++; $display("FAIL mask_data got=%h exp=fffff00000", rsp_rdata);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int n_rsp;
    n_rsp = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        drive(mk(1'b0, 6'(i), 2'b00, 40'h0));
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, req_ready); end
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        total++;
        if (n_rsp >= 8 || rsp_rdata !== exp_mem[n_rsp] || i != n_rsp + 3) begin
          bad++; $display("FAIL b2b_rsp k=%0d cyc=%0d got=%h exp=%h", n_rsp, i, rsp_rdata, exp_mem[n_rsp % 8]);
        end
        n_rsp++;
      end
      tick();
    end
    total++; if (n_rsp != 8) begin bad++; $display("FAIL b2b_count got=%0d exp=8", n_rsp); end
  endtask

  task automatic test_backpressure();
    int  n_acc;
    int  n_rsp;
    bit  acc;
    n_acc = 0;
    n_rsp = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(mk(1'b0, 6'(10 + n_acc), 2'b00, 40'h0));
      acc = req_ready;
      if (rsp_valid) begin
        total++; if (rsp_rdata !== exp_mem[10]) begin bad++; $display("FAIL bp_stall_head got=%h exp=%h", rsp_rdata, exp_mem[10]); end
      end
      tick();
      if (acc) n_acc++;
    end
    total++; if (n_acc != 4) begin bad++; $display("FAIL bp_accepted got=%0d exp=4", n_acc); end
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", req_ready); end
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && (n_acc < 6 || n_rsp < 6); i++) begin
      if (n_acc < 6) drive(mk(1'b0, 6'(10 + n_acc), 2'b00, 40'h0));
      else req_valid = 1'b0;
      acc = req_valid && req_ready;
      if (rsp_valid) begin
        total++;
        if (n_rsp >= 6 || rsp_rdata !== exp_mem[10 + n_rsp]) begin
          bad++; $display("FAIL bp_rsp k=%0d got=%h exp=%h", n_rsp, rsp_rdata, exp_mem[10 + (n_rsp % 6)]);
        end
        n_rsp++;
      end
      tick();
      if (acc) n_acc++;
    end
    req_valid = 1'b0;
    total++; if (n_acc != 6 || n_rsp != 6) begin bad++; $display("FAIL bp_drain got=%0d/%0d exp=6/6", n_acc, n_rsp); end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b1;
    drive(mk(1'b0, 6'd1, 2'b00, 40'h0));
    tick();
    drive(mk(1'b0, 6'd2, 2'b00, 40'h0));
    tick();
    req_valid = 1'b0;
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b exp=1", req_ready); end
    total++; if (csb0 !== 1'b1) begin bad++; $display("FAIL mid_rst_csb0 got=%b exp=1", csb0); end
    total++; if (rsp_rdata !== 40'h0) begin bad++; $display("FAIL mid_rst_rdata got=%h exp=0", rsp_rdata); end
    for (int i = 0; i < 6; i++) begin
      total++;
      if (rsp_valid !== 1'b0 || csb0 !== 1'b1) begin
        bad++; $display("FAIL mid_rst_quiet cyc=%0d got=%b%b exp=01", i, rsp_valid, csb0);
      end
      tick();
    end
  endtask

  task automatic test_contents_kept();
    bit seen;
    rsp_ready = 1'b1;
    drive(mk(1'b0, 6'd5, 2'b00, 40'h0));
    tick();
    req_valid = 1'b0;
    wait_rsp(6, seen);
    total++;
    if (!seen) begin bad++; $display("FAIL kept_timeout got=none exp=response"); end
    else if (rsp_rdata !== 40'hAB_CDEF_0123) begin
      bad++; $display("FAIL kept_data got=%h exp=abcdef0123", rsp_rdata);
    end
    tick();
    tick();
  endtask

  task automatic test_idle();
    int            act0;
    logic          web_prev;
    logic [AW-1:0] addr_prev;
    req_valid = 1'b0;
    tick();
    act0      = act_cnt;
    web_prev  = web0;
    addr_prev = addr0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (csb0 !== 1'b1) begin bad++; $display("FAIL idle_csb0 cyc=%0d got=%b exp=1", i, csb0); end
    end
    total++; if (act_cnt != act0) begin bad++; $display("FAIL idle_activity got=%0d exp=%0d", act_cnt, act0); end
    total++; if (web0 !== web_prev || addr0 !== addr_prev) begin
      bad++; $display("FAIL idle_hold got=%b/%0d exp=%b/%0d", web0, addr0, web_prev, addr_prev);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_contents_kept();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
